// File: rtl/sap2_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sap2_ctrl_pkg
// Shared constants for the SAP-2 controller/sequencer:
//   - control-word width and the bit index of every control line
//   - ALU operation codes carried in the ALU_OP field
//   - opcodes understood by the sequencer
//   - T-state encodings T1..T8
//   - small helpers that build control words from bit indices
// ---------------------------------------------------------------------------
package sap2_ctrl_pkg;

    localparam int CTRL_W = 20;

    typedef logic [CTRL_W-1:0] ctrl_word_t;

    // Control-word bit map
    localparam int CB_PC_OUT     = 0;
    localparam int CB_PC_INC     = 1;
    localparam int CB_PC_LOAD    = 2;
    localparam int CB_MAR_LOAD   = 3;
    localparam int CB_MEM_OUT    = 4;
    localparam int CB_MEM_WRITE  = 5;
    localparam int CB_IR_LOAD    = 6;
    localparam int CB_TMPL_LOAD  = 7;
    localparam int CB_TMPH_LOAD  = 8;
    localparam int CB_TMP_OUT    = 9;
    localparam int CB_A_LOAD     = 10;
    localparam int CB_A_OUT      = 11;
    localparam int CB_B_LOAD     = 12;
    localparam int CB_B_OUT      = 13;
    localparam int CB_ALU_OUT    = 14;
    localparam int CB_ALU_OP_LSB = 15;   // two bits: 16:15
    localparam int CB_FLAGS_LOAD = 17;
    localparam int CB_OUT_LOAD   = 18;
    localparam int CB_SPARE      = 19;   // never driven high

    // ALU operation codes
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_INC = 2'b10;
    localparam logic [1:0] ALU_DEC = 2'b11;

    // Opcodes
    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_MOV_AB = 8'h78;
    localparam logic [7:0] OP_MOV_BA = 8'h47;
    localparam logic [7:0] OP_ADD_B  = 8'h80;
    localparam logic [7:0] OP_SUB_B  = 8'h90;
    localparam logic [7:0] OP_INR_A  = 8'h3C;
    localparam logic [7:0] OP_DCR_A  = 8'h3D;
    localparam logic [7:0] OP_MVI_A  = 8'h3E;
    localparam logic [7:0] OP_OUT    = 8'hD3;
    localparam logic [7:0] OP_LDA    = 8'h3A;
    localparam logic [7:0] OP_STA    = 8'h32;
    localparam logic [7:0] OP_JMP    = 8'hC3;
    localparam logic [7:0] OP_JZ     = 8'hCA;
    localparam logic [7:0] OP_JNZ    = 8'hC2;
    localparam logic [7:0] OP_HLT    = 8'h76;

    // T-states
    localparam logic [3:0] T1 = 4'd1;
    localparam logic [3:0] T2 = 4'd2;
    localparam logic [3:0] T3 = 4'd3;
    localparam logic [3:0] T4 = 4'd4;
    localparam logic [3:0] T5 = 4'd5;
    localparam logic [3:0] T6 = 4'd6;
    localparam logic [3:0] T7 = 4'd7;
    localparam logic [3:0] T8 = 4'd8;

    // One-hot control word for a single bit index
    function automatic ctrl_word_t cbit(input int idx);
        ctrl_word_t one;
        one = ctrl_word_t'(1);
        return one << idx;
    endfunction

    // Register-to-register ALU execute word with the given operation
    function automatic ctrl_word_t alu_word(input logic [1:0] op);
        ctrl_word_t w;
        w = cbit(CB_ALU_OUT) | cbit(CB_A_LOAD) | cbit(CB_FLAGS_LOAD);
        w[CB_ALU_OP_LSB +: 2] = op;
        return w;
    endfunction

endpackage

// File: rtl/t_state_counter.sv
// ---------------------------------------------------------------------------
// t_state_counter
// Holds the current T-state (1..8). Resets asynchronously to T1, advances by
// one on each enabled rising edge, or jumps back to T1 when iRestart marks
// the current state as the last one of the instruction.
//   iClk      in  1  clock
//   iReset_n  in  1  asynchronous active-low reset (to T1)
//   iEnable   in  1  advance/restart allowed on this edge
//   iRestart  in  1  current state ends the instruction
//   oTState   out 4  current T-state
// ---------------------------------------------------------------------------
module t_state_counter
    import sap2_ctrl_pkg::*;
(
    input  logic       iClk,
    input  logic       iReset_n,
    input  logic       iEnable,
    input  logic       iRestart,
    output logic [3:0] oTState
);

    logic [3:0] tstate_d;
    logic [3:0] tstate_q;

    always_comb begin
        tstate_d = tstate_q;
        if (iEnable) begin
            tstate_d = iRestart ? T1 : (tstate_q + 4'd1);
        end
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            tstate_q <= T1;
        end else begin
            tstate_q <= tstate_d;
        end
    end

    assign oTState = tstate_q;

endmodule

// File: rtl/controller_sequencer.sv
// ---------------------------------------------------------------------------
// controller_sequencer
// SAP-2 control unit. T1/T2 fetch the opcode into the IR; from T3 onward the
// opcode in iInstruction selects the execute sequence. oCtrl is purely
// combinational from (T-state, opcode, iZero, iRun, halted, reset).
//   iClk          in  1   system clock
//   iReset_n      in  1   asynchronous active-low reset
//   iInstruction  in  8   IR contents, meaningful from T3 on
//   iZero         in  1   zero flag, used in T7 of JZ/JNZ
//   iRun          in  1   0 freezes the sequencer and blanks oCtrl
//   oCtrl         out 20  control word (bit map in sap2_ctrl_pkg)
//   oTState       out 4   current T-state (state observation)
//   oHalted       out 1   HLT has executed
//   oIllegal      out 1   unknown opcode, during its T3
// ---------------------------------------------------------------------------
module controller_sequencer
    import sap2_ctrl_pkg::*;
(
    input  logic              iClk,
    input  logic              iReset_n,
    input  logic [7:0]        iInstruction,
    input  logic              iZero,
    input  logic              iRun,
    output logic [CTRL_W-1:0] oCtrl,
    output logic [3:0]        oTState,
    output logic              oHalted,
    output logic              oIllegal
);

    logic [3:0]  t_state;
    logic        halted_d;
    logic        halted_q;
    logic        active;
    logic        last_state;
    logic        hlt_exec;
    logic        unknown_op;
    ctrl_word_t  ctrl_dec;

    // Operand-fetch pair: address the byte at PC, then read it and step PC
    localparam ctrl_word_t OF_ADDR = ctrl_word_t'(1 << CB_PC_OUT) | ctrl_word_t'(1 << CB_MAR_LOAD);
    localparam ctrl_word_t OF_READ = ctrl_word_t'(1 << CB_MEM_OUT) | ctrl_word_t'(1 << CB_PC_INC);

    assign active = iRun & ~halted_q;

    // Decode: fetch states ignore the IR (it still holds the previous opcode)
    always_comb begin
        ctrl_dec   = '0;
        last_state = 1'b0;
        hlt_exec   = 1'b0;
        unknown_op = 1'b0;
        case (t_state)
            T1: ctrl_dec = OF_ADDR;
            T2: ctrl_dec = cbit(CB_MEM_OUT) | cbit(CB_IR_LOAD) | cbit(CB_PC_INC);
            default: begin
                case (iInstruction)
                    OP_NOP:    last_state = 1'b1;
                    OP_MOV_AB: begin ctrl_dec = cbit(CB_B_OUT) | cbit(CB_A_LOAD); last_state = 1'b1; end
                    OP_MOV_BA: begin ctrl_dec = cbit(CB_A_OUT) | cbit(CB_B_LOAD); last_state = 1'b1; end
                    OP_ADD_B:  begin ctrl_dec = alu_word(ALU_ADD); last_state = 1'b1; end
                    OP_SUB_B:  begin ctrl_dec = alu_word(ALU_SUB); last_state = 1'b1; end
                    OP_INR_A:  begin ctrl_dec = alu_word(ALU_INC); last_state = 1'b1; end
                    OP_DCR_A:  begin ctrl_dec = alu_word(ALU_DEC); last_state = 1'b1; end
                    OP_MVI_A: begin
                        if (t_state == T3) begin
                            ctrl_dec = OF_ADDR;
                        end else begin
                            ctrl_dec   = OF_READ | cbit(CB_A_LOAD);
                            last_state = 1'b1;
                        end
                    end
                    OP_OUT: begin
                        // Port byte is not used: just step PC over it
                        if (t_state == T3) begin
                            ctrl_dec = cbit(CB_PC_INC);
                        end else begin
                            ctrl_dec   = cbit(CB_A_OUT) | cbit(CB_OUT_LOAD);
                            last_state = 1'b1;
                        end
                    end
                    OP_LDA, OP_STA, OP_JMP, OP_JZ, OP_JNZ: begin
                        case (t_state)
                            T3: ctrl_dec = OF_ADDR;
                            T4: ctrl_dec = OF_READ | cbit(CB_TMPL_LOAD);
                            T5: ctrl_dec = OF_ADDR;
                            T6: ctrl_dec = OF_READ | cbit(CB_TMPH_LOAD);
                            T7: begin
                                case (iInstruction)
                                    OP_LDA, OP_STA: ctrl_dec = cbit(CB_TMP_OUT) | cbit(CB_MAR_LOAD);
                                    OP_JMP: begin ctrl_dec = cbit(CB_PC_LOAD); last_state = 1'b1; end
                                    OP_JZ: begin
                                        ctrl_dec   = iZero ? cbit(CB_PC_LOAD) : '0;
                                        last_state = 1'b1;
                                    end
                                    default: begin   // JNZ
                                        ctrl_dec   = iZero ? '0 : cbit(CB_PC_LOAD);
                                        last_state = 1'b1;
                                    end
                                endcase
                            end
                            default: begin
                                // T8; also forces recovery for any out-of-range state
                                if (iInstruction == OP_LDA) begin
                                    ctrl_dec = cbit(CB_MEM_OUT) | cbit(CB_A_LOAD);
                                end else if (iInstruction == OP_STA) begin
                                    ctrl_dec = cbit(CB_A_OUT) | cbit(CB_MEM_WRITE);
                                end
                                last_state = 1'b1;
                            end
                        endcase
                    end
                    OP_HLT: hlt_exec = 1'b1;
                    default: begin
                        unknown_op = 1'b1;
                        last_state = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // HLT's T3 is not "last": the counter must stay parked at T3 once halted
    assign halted_d = halted_q | (active & hlt_exec);

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    t_state_counter u_t_state_counter (
        .iClk     (iClk),
        .iReset_n (iReset_n),
        .iEnable  (active & ~hlt_exec),
        .iRestart (last_state),
        .oTState  (t_state)
    );

    assign oCtrl    = (iReset_n & active) ? ctrl_dec : '0;
    assign oIllegal = iReset_n & active & unknown_op;
    assign oTState  = t_state;
    assign oHalted  = halted_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// ---------------------------------------------------------------------------
// tb_controller_sequencer
// Directed and randomized instruction streams for controller_sequencer. The
// reference model expands each opcode into the full list of control words
// the instruction must produce, one per T-state, and the bench walks that
// list cycle by cycle (with optional pauses) comparing against the DUT.
// ---------------------------------------------------------------------------
module tb_controller_sequencer;
    import sap2_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        instr;
    logic              zero;
    logic              run;
    logic [CTRL_W-1:0] ctrl;
    logic [3:0]        tst;
    logic              halted;
    logic              illegal;

    int total = 0;
    int bad   = 0;

    logic [CTRL_W-1:0] exp_q[$];
    bit                exp_illegal;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    controller_sequencer dut (
        .iClk         (clk),
        .iReset_n     (rst_n),
        .iInstruction (instr),
        .iZero        (zero),
        .iRun         (run),
        .oCtrl        (ctrl),
        .oTState      (tst),
        .oHalted      (halted),
        .oIllegal     (illegal)
    );

    // ---------------- reference model ----------------
    function automatic logic [CTRL_W-1:0] m(input int b);
        logic [CTRL_W-1:0] one;
        one = 1;
        return one << b;
    endfunction

    function automatic logic [CTRL_W-1:0] alu(input int code);
        logic [CTRL_W-1:0] w;
        w = m(CB_ALU_OUT) | m(CB_A_LOAD) | m(CB_FLAGS_LOAD);
        if (code & 1) w = w | m(CB_ALU_OP_LSB);
        if (code & 2) w = w | m(CB_ALU_OP_LSB + 1);
        return w;
    endfunction

    // Expand one instruction into its per-T-state control words
    task automatic build(input logic [7:0] op, input logic z);
        logic [CTRL_W-1:0] ofa;
        logic [CTRL_W-1:0] ofb;
        ofa = m(CB_PC_OUT) | m(CB_MAR_LOAD);
        ofb = m(CB_MEM_OUT) | m(CB_PC_INC);
        exp_q.delete();
        exp_illegal = 0;
        exp_q.push_back(m(CB_PC_OUT) | m(CB_MAR_LOAD));
        exp_q.push_back(m(CB_MEM_OUT) | m(CB_IR_LOAD) | m(CB_PC_INC));
        case (op)
            8'h00, 8'h76: exp_q.push_back('0);
            8'h78: exp_q.push_back(m(CB_B_OUT) | m(CB_A_LOAD));
            8'h47: exp_q.push_back(m(CB_A_OUT) | m(CB_B_LOAD));
            8'h80: exp_q.push_back(alu(0));
            8'h90: exp_q.push_back(alu(1));
            8'h3C: exp_q.push_back(alu(2));
            8'h3D: exp_q.push_back(alu(3));
            8'h3E: begin exp_q.push_back(ofa); exp_q.push_back(ofb | m(CB_A_LOAD)); end
            8'hD3: begin exp_q.push_back(m(CB_PC_INC)); exp_q.push_back(m(CB_A_OUT) | m(CB_OUT_LOAD)); end
            8'h3A, 8'h32, 8'hC3, 8'hCA, 8'hC2: begin
                exp_q.push_back(ofa);
                exp_q.push_back(ofb | m(CB_TMPL_LOAD));
                exp_q.push_back(ofa);
                exp_q.push_back(ofb | m(CB_TMPH_LOAD));
                if (op == 8'h3A) begin
                    exp_q.push_back(m(CB_TMP_OUT) | m(CB_MAR_LOAD));
                    exp_q.push_back(m(CB_MEM_OUT) | m(CB_A_LOAD));
                end else if (op == 8'h32) begin
                    exp_q.push_back(m(CB_TMP_OUT) | m(CB_MAR_LOAD));
                    exp_q.push_back(m(CB_A_OUT) | m(CB_MEM_WRITE));
                end else if (op == 8'hC3) begin
                    exp_q.push_back(m(CB_PC_LOAD));
                end else begin
                    exp_q.push_back(((op == 8'hCA) == (z == 1'b1)) ? m(CB_PC_LOAD) : '0);
                end
            end
            default: begin exp_q.push_back('0); exp_illegal = 1; end
        endcase
    endtask

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ---------------- driver ----------------
    // Entered just after a rising edge, at the start of T1. The IR changes
    // only after the edge ending T2; iZero is random except in T7.
    task automatic run_instr(input logic [7:0] op, input logic z, input int pause_at, input int pause_len);
        int n;
        build(op, z);
        n = exp_q.size();
        for (int s = 1; s <= n; s++) begin
            logic [CTRL_W-1:0] e;
            e = exp_q.pop_front();
            if (s == 3) instr = op;
            zero = (s == 7) ? z : 1'($urandom_range(0, 1));
            if (s == pause_at) begin
                for (int p = 0; p < pause_len; p++) begin
                    run = 1'b0;
                    @(negedge clk);
                    chk($sformatf("pause op=%02h T%0d ctrl", op, s), 32'(ctrl), 32'(0));
                    chk($sformatf("pause op=%02h T%0d tstate", op, s), 32'(tst), 32'(s));
                    chk($sformatf("pause op=%02h T%0d illegal", op, s), 32'(illegal), 32'(0));
                    @(posedge clk); #1;
                end
            end
            run = 1'b1;
            @(negedge clk);
            chk($sformatf("op=%02h T%0d ctrl", op, s), 32'(ctrl), 32'(e));
            chk($sformatf("op=%02h T%0d tstate", op, s), 32'(tst), 32'(s));
            chk($sformatf("op=%02h T%0d illegal", op, s), 32'(illegal), 32'(exp_illegal && s == 3));
            chk($sformatf("op=%02h T%0d halted", op, s), 32'(halted), 32'(0));
            @(posedge clk); #1;
        end
    endtask

    logic [7:0] op_tab [14] = '{8'h00, 8'h78, 8'h47, 8'h80, 8'h90, 8'h3C, 8'h3D,
                                8'h3E, 8'hD3, 8'h3A, 8'h32, 8'hC3, 8'hCA, 8'hC2};

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] rop;
        rst_n = 1'b0;
        run   = 1'b1;
        instr = 8'h00;
        zero  = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ctrl", 32'(ctrl), 32'(0));
        chk("reset tstate", 32'(tst), 32'(1));
        chk("reset halted", 32'(halted), 32'(0));
        chk("reset illegal", 32'(illegal), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed instructions
        run_instr(8'h00, 1'b0, 0, 0);
        run_instr(8'h3A, 1'b0, 0, 0);
        run_instr(8'hCA, 1'b1, 0, 0);
        run_instr(8'hCA, 1'b0, 0, 0);
        run_instr(8'hC2, 1'b1, 0, 0);
        run_instr(8'hC2, 1'b0, 0, 0);
        run_instr(8'h90, 1'b0, 0, 0);
        run_instr(8'hFF, 1'b0, 0, 0);
        run_instr(8'h00, 1'b0, 0, 0);
        run_instr(8'h32, 1'b0, 5, 5);
        run_instr(8'h3E, 1'b0, 0, 0);
        run_instr(8'hD3, 1'b0, 0, 0);
        run_instr(8'hC3, 1'b0, 0, 0);

        // Randomized stream with occasional pauses
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                rop = 8'($urandom_range(0, 255));
                if (rop == 8'h76) rop = 8'h00;
            end else begin
                rop = op_tab[$urandom_range(0, 13)];
            end
            run_instr(rop, 1'($urandom_range(0, 1)), $urandom_range(0, 12), $urandom_range(1, 3));
        end

        // Halt: flag rises after T3, T-state parks at 3, ctrl stays 0
        run_instr(8'h76, 1'b0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            run = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("halt halted", 32'(halted), 32'(1));
            chk("halt tstate", 32'(tst), 32'(3));
            chk("halt ctrl", 32'(ctrl), 32'(0));
            chk("halt illegal", 32'(illegal), 32'(0));
            @(posedge clk); #1;
        end
        run = 1'b1;

        // Reset during halt
        rst_n = 1'b0;
        #1;
        chk("halt reset halted", 32'(halted), 32'(0));
        chk("halt reset tstate", 32'(tst), 32'(1));
        chk("halt reset ctrl", 32'(ctrl), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_instr(8'h80, 1'b0, 0, 0);

        // Reset mid-instruction: abandon an LDA at T5, then fetch afresh
        build(8'h3A, 1'b0);
        instr = 8'h00;
        repeat (2) begin @(posedge clk); #1; end
        instr = 8'h3A;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("mid LDA tstate", 32'(tst), 32'(5));
        rst_n = 1'b0;
        #1;
        chk("mid reset tstate", 32'(tst), 32'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_instr(8'h3D, 1'b0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
